retire_write_responder: RTL and testbench

Responder side of the retire/write-back handshake. Detects a retire request (write_en & data_valid with a stable 5-bit tag over two write_en cycles), then issues the matching write within a bounded window of MIN_DELAY..MAX_DELAY cycles after the second retire beat, on the first cycle the shared bus shows write_en && !data_valid. It sits between the retire stage and the write port and is the active counterpart of the retire→write implication assertions.

---
 rtl/retire_write_responder.sv | 123 ++++++++++++
 tb/tb_retire_write_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/retire_write_responder.sv
// Responder for the retire/write-back handshake: confirms a two-beat retire request,
// then issues the matching write on the first free bus cycle inside a bounded window.
module retire_write_responder #(
    parameter int MIN_DELAY = 3,
    parameter int MAX_DELAY = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       write_en,
    input  logic       data_valid,
    input  logic [0:8] retire_address,
    output logic [0:8] write_address,
    output logic       wr_strobe,
    output logic       busy,
    output logic       seq_err,
    output logic       timeout,
    output logic       drop
);

    generate
        if (MIN_DELAY < 1 || MAX_DELAY < MIN_DELAY || MAX_DELAY > 15) begin : g_bad_params
            $error("retire_write_responder: need 1 <= MIN_DELAY <= MAX_DELAY <= 15");
        end
    endgenerate

    localparam logic [3:0] MIN_K = 4'(MIN_DELAY);
    localparam logic [3:0] MAX_K = 4'(MAX_DELAY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_WAIT,
        ST_ISSUE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] k_q, k_d;
    logic [0:4] tag_q, tag_d;
    logic [0:3] low_q, low_d;

    logic start, bus_ready, tag_match;

    assign start     = write_en & data_valid;
    assign bus_ready = write_en & ~data_valid;
    assign tag_match = (retire_address[0:4] == tag_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= 4'd0;
            tag_q   <= 5'd0;
            low_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tag_q   <= tag_d;
            low_q   <= low_d;
        end
    end

    // k counts the offset from the second retire beat; it tops out at MAX_DELAY so it never wraps.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tag_d   = tag_q;
        low_d   = low_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tag_d   = retire_address[0:4];
                    low_d   = retire_address[5:8];
                    state_d = ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (write_en && tag_match) begin
                    k_d     = 4'd1;
                    state_d = (MIN_K == 4'd1) ? ST_ISSUE : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                k_d = k_q + 4'd1;
                if (k_q + 4'd1 == MIN_K) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus_ready || k_q == MAX_K) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pulses are suppressed while reset is asserted so an aborted transaction leaves no trace.
    always_comb begin
        wr_strobe = 1'b0;
        seq_err   = 1'b0;
        timeout   = 1'b0;
        drop      = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_CONFIRM: seq_err = ~(write_en & tag_match);
                ST_WAIT:    drop    = start;
                ST_ISSUE: begin
                    drop      = start;
                    wr_strobe = bus_ready;
                    timeout   = ~bus_ready & (k_q == MAX_K);
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign write_address = {tag_q, low_q};

endmodule

// File: tb/tb_retire_write_responder.sv
// Scoreboard bench: two responders (3..8 and 1..1 windows) share one stimulus stream and are
// checked every cycle against an offset-based transaction model.
module tb_retire_write_responder;

    logic       clk;
    logic       rst_n;
    logic       writeEn;
    logic       dataValid;
    logic [0:8] retireAddr;

    logic [0:8] writeAddr [2];
    logic       wrStrobe  [2];
    logic       busyO     [2];
    logic       seqErr    [2];
    logic       timeoutO  [2];
    logic       dropO     [2];

    retire_write_responder #(.MIN_DELAY(3), .MAX_DELAY(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .write_en(writeEn), .data_valid(dataValid),
        .retire_address(retireAddr), .write_address(writeAddr[0]), .wr_strobe(wrStrobe[0]),
        .busy(busyO[0]), .seq_err(seqErr[0]), .timeout(timeoutO[0]), .drop(dropO[0])
    );

    retire_write_responder #(.MIN_DELAY(1), .MAX_DELAY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .write_en(writeEn), .data_valid(dataValid),
        .retire_address(retireAddr), .write_address(writeAddr[1]), .wr_strobe(wrStrobe[1]),
        .busy(busyO[1]), .seq_err(seqErr[1]), .timeout(timeoutO[1]), .drop(dropO[1])
    );

    // pulses packs {wr_strobe, seq_err, timeout, drop}
    typedef struct {
        int         cyc;
        logic [0:8] addr;
        logic       busy;
        logic [3:0] pulses;
    } exp_t;

    exp_t expQ [2][$];

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mActive [2];
    int         mStart  [2];
    logic [0:8] mAddr   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: everything is derived from the offset to the start cycle.
    task automatic modelStep(input int d, input int minD, input int maxD,
                             input logic rst, input logic we, input logic dv,
                             input logic [0:8] ra);
        exp_t e;
        int   o;
        logic s;
        s        = we & dv;
        e.cyc    = cyc;
        e.busy   = mActive[d];
        e.addr   = mAddr[d];
        e.pulses = 4'b0000;
        if (!rst) begin
            mActive[d] = 1'b0;
            mAddr[d]   = 9'h000;
        end else if (!mActive[d]) begin
            if (s) begin
                mActive[d] = 1'b1;
                mStart[d]  = cyc;
                mAddr[d]   = ra;
            end
        end else begin
            o = cyc - mStart[d] - 1;
            if (o == 0) begin
                if (!(we && ra[0:4] == mAddr[d][0:4])) begin
                    e.pulses[2] = 1'b1;
                    mActive[d]  = 1'b0;
                end
            end else begin
                e.pulses[0] = s;
                if (o >= minD && we && !dv) begin
                    e.pulses[3] = 1'b1;
                    mActive[d]  = 1'b0;
                end else if (o == maxD) begin
                    e.pulses[1] = 1'b1;
                    mActive[d]  = 1'b0;
                end
            end
        end
        expQ[d].push_back(e);
    endtask

    task automatic applyStimulus(input logic rst, input logic we, input logic dv,
                                 input logic [0:8] ra);
        @(posedge clk);
        #1;
        rst_n      = rst;
        writeEn    = we;
        dataValid  = dv;
        retireAddr = ra;
        modelStep(0, 3, 8, rst, we, dv, ra);
        modelStep(1, 1, 1, rst, we, dv, ra);
    endtask

    task automatic checkOutput(input int d, input exp_t e);
        logic [3:0] gotPulses;
        gotPulses = {wrStrobe[d], seqErr[d], timeoutO[d], dropO[d]};
        checks++;
        if (gotPulses !== e.pulses) begin
            errors++;
            $display("[TB] FAIL dut%0d pulses cyc %0d got %b expected %b (wr,seq,tmo,drop)",
                     d, e.cyc, gotPulses, e.pulses);
        end
        checks++;
        if (busyO[d] !== e.busy || writeAddr[d] !== e.addr) begin
            errors++;
            $display("[TB] FAIL dut%0d busy/addr cyc %0d got %b/%h expected %b/%h",
                     d, e.cyc, busyO[d], writeAddr[d], e.busy, e.addr);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (expQ[d].size() > 0) begin
                checkOutput(d, expQ[d].pop_front());
            end
        end
    end

    initial begin
        logic [0:8] lastRa;
        logic [0:8] ra;
        rst_n      = 1'b0;
        writeEn    = 1'b0;
        dataValid  = 1'b0;
        retireAddr = 9'h000;
        for (int d = 0; d < 2; d++) begin
            mActive[d] = 1'b0;
            mStart[d]  = 0;
            mAddr[d]   = 9'h000;
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);

        // Defaults: earliest write with an idle bus
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h1A5);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'h1A5);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 9'h000);

        // Stall until T+7, then stall through the full window
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h1A5);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h1A5);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b1, 9'h000);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 9'h000);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h0C3);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'h0C3);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b1, 9'h000);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);

        // Broken second beat: wrong tag, then write_en low
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h1A5);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'h0A5);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h155);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h155);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);

        // Overlapping starts while a write is pending
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h1F0);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h1F0);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h00F);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h0AA);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'h000);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);

        // Reset while waiting, then a clean transaction two cycles later
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h1A5);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'h1A5);
        applyStimulus(1'b0, 1'b1, 1'b1, 9'h033);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'h07E);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'h07E);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 9'h000);

        // Randomized traffic; addresses are often repeated so second beats usually confirm
        lastRa = 9'h1A5;
        for (int i = 0; i < 1500; i++) begin
            ra = ($urandom_range(3) != 0) ? lastRa : 9'($urandom);
            lastRa = ra;
            applyStimulus(($urandom_range(63) != 0), ($urandom_range(3) != 0),
                          1'($urandom_range(1)), ra);
        end

        @(posedge clk);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (expQ[d].size() != 0) begin
                errors++;
                $display("[TB] FAIL dut%0d drain leftover %0d expected 0", d, expQ[d].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
